dpram_be_init: RTL and testbench

DPRAM_BE_INIT -- requirements
Module: dpram_be_init

---
 rtl/dpram_be_init.sv | 170 +++++++++++++++++
 tb/tb_dpram_be_init.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be_init.sv
// Dual-port RAM with per-lane write enables, post-reset clear sweep,
// configurable cross-port read-during-write behaviour and optional output stage.
module dpram_be_init #(
  parameter int unsigned ADRW      = 8,
  parameter int unsigned DATW      = 32,
  parameter int unsigned LANEW     = 8,
  parameter int unsigned RDW_MODE  = 0,
  parameter int unsigned OUTREG    = 0,
  parameter logic [DATW-1:0] CLEAR_VAL = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    init_busy,
  output logic                    collision,
  input  logic                    wren_a,
  input  logic                    wren_b,
  input  logic                    rden_a,
  input  logic                    rden_b,
  input  logic [ADRW-1:0]         address_a,
  input  logic [ADRW-1:0]         address_b,
  input  logic [DATW/LANEW-1:0]   be_a,
  input  logic [DATW/LANEW-1:0]   be_b,
  input  logic [DATW-1:0]         data_a,
  input  logic [DATW-1:0]         data_b,
  output logic [DATW-1:0]         q_a,
  output logic [DATW-1:0]         q_b,
  output logic                    valid_a,
  output logic                    valid_b
);

  localparam int unsigned MEMD = 2**ADRW;
  localparam int unsigned NL   = DATW / LANEW;
  localparam int unsigned CNTW = ADRW + 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              clr_we;

  logic [DATW-1:0]   mem [MEMD];

  logic              we_a, we_b, re_a, re_b;
  logic              same_addr;
  logic [DATW-1:0]   rdata_a, rdata_b;

  // Replace the lanes selected by be in old_w with the lanes of new_w.
  function automatic logic [DATW-1:0] lane_merge(input logic [DATW-1:0] old_w,
                                                 input logic [DATW-1:0] new_w,
                                                 input logic [NL-1:0]   be);
    lane_merge = old_w;
    for (int i = 0; i < NL; i++) begin
      if (be[i]) lane_merge[i*LANEW +: LANEW] = new_w[i*LANEW +: LANEW];
    end
  endfunction

  // State and sweep counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep sequencing: one word cleared per cycle, then hand over to user ports.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(MEMD - 1)) state_d = READY;
      end
      READY: begin
        state_d = READY;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign init_busy = (state_q == CLEAR);

  // User requests are only honoured once the sweep has finished; write wins over read.
  always_comb begin
    we_a      = (state_q == READY) && wren_a;
    we_b      = (state_q == READY) && wren_b;
    re_a      = (state_q == READY) && rden_a && !wren_a;
    re_b      = (state_q == READY) && rden_b && !wren_b;
    same_addr = (address_a == address_b);
  end

  // Read data, optionally forwarding the other port's same-cycle write lanes.
  always_comb begin
    rdata_a = mem[address_a];
    rdata_b = mem[address_b];
    if (RDW_MODE != 0) begin
      if (we_b && same_addr) rdata_a = lane_merge(mem[address_a], data_b, be_b);
      if (we_a && same_addr) rdata_b = lane_merge(mem[address_b], data_a, be_a);
    end
  end

  // Memory array: clear sweep, else per-lane writes with port B winning shared lanes.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[cnt_q[ADRW-1:0]] <= CLEAR_VAL;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (we_a && be_a[i]) mem[address_a][i*LANEW +: LANEW] <= data_a[i*LANEW +: LANEW];
      end
      for (int i = 0; i < NL; i++) begin
        if (we_b && be_b[i]) mem[address_b][i*LANEW +: LANEW] <= data_b[i*LANEW +: LANEW];
      end
    end
  end

  // Collision flag: both ports wrote a shared lane of the same word last cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) collision <= 1'b0;
    else       collision <= we_a && we_b && same_addr && (|(be_a & be_b));
  end

  if (OUTREG != 0) begin : g_outreg
    logic [DATW-1:0] p_q_a, p_q_b;
    logic            p_v_a, p_v_b;

    // Two-stage read pipeline; q only moves when a valid word reaches it.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        p_q_a   <= '0;
        p_q_b   <= '0;
        p_v_a   <= 1'b0;
        p_v_b   <= 1'b0;
        q_a     <= '0;
        q_b     <= '0;
        valid_a <= 1'b0;
        valid_b <= 1'b0;
      end else begin
        p_v_a   <= re_a;
        p_v_b   <= re_b;
        if (re_a) p_q_a <= rdata_a;
        if (re_b) p_q_b <= rdata_b;
        valid_a <= p_v_a;
        valid_b <= p_v_b;
        if (p_v_a) q_a <= p_q_a;
        if (p_v_b) q_b <= p_q_b;
      end
    end
  end else begin : g_direct
    // Single-stage read output; q holds between reads.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        q_a     <= '0;
        q_b     <= '0;
        valid_a <= 1'b0;
        valid_b <= 1'b0;
      end else begin
        valid_a <= re_a;
        valid_b <= re_b;
        if (re_a) q_a <= rdata_a;
        if (re_b) q_b <= rdata_b;
      end
    end
  end

endmodule

// File: tb/tb_dpram_be_init.sv
// Scoreboard bench: two instances (old-data/latency-1 and new-data/latency-2) share stimulus.
module tb_dpram_be_init;

  localparam logic [31:0] CV = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren_a, wren_b, rden_a, rden_b;
  logic [3:0]  address_a, address_b;
  logic [3:0]  be_a, be_b;
  logic [31:0] data_a, data_b;

  logic        init_busy0, collision0, valid_a0, valid_b0;
  logic [31:0] q_a0, q_b0;
  logic        init_busy1, collision1, valid_a1, valid_b1;
  logic [31:0] q_a1, q_b1;

  typedef struct {
    logic [31:0] d;
    int          due;
  } rd_t;

  rd_t         sb [4][$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mv [4];
  logic [31:0] mq [4];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dpram_be_init #(.ADRW(4), .DATW(32), .LANEW(8), .RDW_MODE(0), .OUTREG(0),
                  .CLEAR_VAL(CV)) u0 (
    .clock(clock), .reset(reset), .init_busy(init_busy0), .collision(collision0),
    .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
    .address_a(address_a), .address_b(address_b), .be_a(be_a), .be_b(be_b),
    .data_a(data_a), .data_b(data_b), .q_a(q_a0), .q_b(q_b0),
    .valid_a(valid_a0), .valid_b(valid_b0));

  dpram_be_init #(.ADRW(4), .DATW(32), .LANEW(8), .RDW_MODE(1), .OUTREG(1),
                  .CLEAR_VAL(CV)) u1 (
    .clock(clock), .reset(reset), .init_busy(init_busy1), .collision(collision1),
    .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
    .address_a(address_a), .address_b(address_b), .be_a(be_a), .be_b(be_b),
    .data_a(data_a), .data_b(data_b), .q_a(q_a1), .q_b(q_b1),
    .valid_a(valid_a1), .valid_b(valid_b1));

  assign mv[0] = valid_a0;
  assign mv[1] = valid_b0;
  assign mv[2] = valid_a1;
  assign mv[3] = valid_b1;
  assign mq[0] = q_a0;
  assign mq[1] = q_b0;
  assign mq[2] = q_a1;
  assign mq[3] = q_b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the head of its stream's queue, on time.
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      while (sb[i].size() != 0 && sb[i][0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_valid stream %0d: got none expected %h at cycle %0d",
                 i, sb[i][0].d, sb[i][0].due);
        void'(sb[i].pop_front());
      end
      if (mv[i]) begin
        checks++;
        if (sb[i].size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid stream %0d: got %h expected no valid", i, mq[i]);
        end else begin
          rd_t e;
          e = sb[i].pop_front();
          if (mq[i] !== e.d || e.due != cyc) begin
            failures++;
            $display("FAIL read stream %0d: got %h at cycle %0d expected %h at cycle %0d",
                     i, mq[i], cyc, e.d, e.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wren_a = 0; wren_b = 0; rden_a = 0; rden_b = 0;
    be_a = '0; be_b = '0;
  endtask

  // Port p: 0 = A, 1 = B. e0 for old-data/latency-1 instance, e1 for new-data/latency-2.
  task automatic exp_rd(input int p, input logic [31:0] e0, input logic [31:0] e1);
    rd_t r;
    r.d = e0; r.due = cyc + 1; sb[p].push_back(r);
    r.d = e1; r.due = cyc + 2; sb[2 + p].push_back(r);
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    if (p == 0) begin wren_a = 1; address_a = a; data_a = d; be_a = be; end
    else        begin wren_b = 1; address_b = a; data_b = d; be_b = be; end
  endtask

  task automatic rd(input int p, input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
    if (p == 0) begin rden_a = 1; address_a = a; end
    else        begin rden_b = 1; address_b = a; end
    exp_rd(p, e0, e1);
  endtask

  // Garbage requests that must be ignored while the clear sweep runs.
  task automatic junk(input int n);
    wren_a = 1; address_a = 4'(n); data_a = 32'hA5A50000 | 32'(n); be_a = 4'b1111;
    rden_b = 1; address_b = 4'(n + 1); wren_b = n[0]; data_b = 32'h0; be_b = 4'b1111;
  endtask

  task automatic sweep(input bit stim, output int n);
    n = 0;
    while (init_busy0 && n < 40) begin
      if (stim) junk(n);
      tick();
      n++;
    end
    idle();
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) sb[i].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1;
    address_a = '0; address_b = '0; data_a = '0; data_b = '0;
    idle();
    tick(); tick();
    chk("rst_q_a0", q_a0, 0);
    chk("rst_valid_a0", 32'(valid_a0), 0);
    chk("rst_collision0", 32'(collision0), 0);
    chk("rst_busy0", 32'(init_busy0), 1);
    chk("rst_q_b1", q_b1, 0);
    chk("rst_busy1", 32'(init_busy1), 1);

    reset = 0;
    sweep(0, n);
    chk("busy_cycles", 32'(n), 16);
    chk("busy1_low", 32'(init_busy1), 0);

    // Whole array holds the clear value; A ascending, B descending, back-to-back.
    for (int i = 0; i < 16; i++) begin
      rd(0, 4'(i), CV, CV);
      rd(1, 4'(15 - i), CV, CV);
      tick();
    end
    idle();

    // Lane-masked overwrite.
    wr(0, 4'd3, 32'h11223344, 4'b1111); tick();
    wr(0, 4'd3, 32'hAABBCCDD, 4'b0101); tick();
    idle();
    rd(0, 4'd3, 32'h11BB33DD, 32'h11BB33DD); tick();
    idle();
    tick(); tick(); tick();
    chk("hold_q_a0", q_a0, 32'h11BB33DD);
    chk("hold_q_a1", q_a1, 32'h11BB33DD);
    chk("hold_valid_a1", 32'(valid_a1), 0);

    // Same-address dual write with one shared lane.
    wr(0, 4'd5, 32'hFFFFFFFF, 4'b0011);
    wr(1, 4'd5, 32'h00000000, 4'b0110);
    tick();
    idle();
    chk("collision0_pulse", 32'(collision0), 1);
    chk("collision1_pulse", 32'(collision1), 1);
    tick();
    chk("collision0_clear", 32'(collision0), 0);
    rd(1, 4'd5, 32'hDE0000FF, 32'hDE0000FF); tick();
    idle();

    // Same-address dual write, disjoint lanes: no collision.
    wr(0, 4'd12, 32'hAAAAAAAA, 4'b1100);
    wr(1, 4'd12, 32'hBBBBBBBB, 4'b0011);
    tick();
    idle();
    chk("no_collision0", 32'(collision0), 0);
    chk("no_collision1", 32'(collision1), 0);
    rd(0, 4'd12, 32'hAAAABBBB, 32'hAAAABBBB); tick();
    idle();

    // Cross-port read during write, full word.
    wr(0, 4'd7, 32'h00000000, 4'b1111); tick();
    idle();
    rd(0, 4'd7, 32'h00000000, 32'h12345678);
    wr(1, 4'd7, 32'h12345678, 4'b1111);
    tick();
    idle();
    rd(0, 4'd7, 32'h12345678, 32'h12345678); tick();
    idle();

    // Cross-port read during write, single lane.
    rd(0, 4'd10, CV, 32'h55ADBEEF);
    wr(1, 4'd10, 32'h55000000, 4'b1000);
    tick();
    idle();
    rd(1, 4'd10, 32'h55ADBEEF, 32'h55ADBEEF); tick();
    idle();

    // Write and read on the same port in one cycle: write only, no valid.
    wren_a = 1; rden_a = 1; address_a = 4'd9; data_a = 32'h0BADF00D; be_a = 4'b1111;
    tick();
    idle();
    be_a = 4'b0000; wren_a = 1; address_a = 4'd9; data_a = 32'h0; tick();
    idle();
    rd(0, 4'd9, 32'h0BADF00D, 32'h0BADF00D); tick();
    idle();

    // Independent ports, different addresses, then back-to-back reads.
    wr(0, 4'd1, 32'h01010101, 4'b1111);
    wr(1, 4'd2, 32'h02020202, 4'b1111);
    tick();
    idle();
    rd(0, 4'd2, 32'h02020202, 32'h02020202);
    rd(1, 4'd1, 32'h01010101, 32'h01010101);
    tick();
    idle();
    rd(0, 4'd1, 32'h01010101, 32'h01010101); tick();
    rd(0, 4'd2, 32'h02020202, 32'h02020202); tick();
    rd(0, 4'd3, 32'h11BB33DD, 32'h11BB33DD); tick();
    idle();
    tick(); tick(); tick();

    // Reset with a read in flight: outputs clear at once, read never reported.
    rd(0, 4'd3, 32'h0, 32'h0); tick();
    idle();
    reset = 1;
    flush();
    #1;
    chk("arst_q_a0", q_a0, 0);
    chk("arst_q_a1", q_a1, 0);
    chk("arst_busy0", 32'(init_busy0), 1);
    tick(); tick();
    reset = 0;

    // Interrupt the sweep at counter 9, then a full sweep under junk requests.
    for (int i = 0; i < 9; i++) begin
      junk(i);
      tick();
    end
    idle();
    reset = 1;
    tick();
    reset = 0;
    sweep(1, n);
    chk("busy_cycles_restart", 32'(n), 16);
    chk("sweep_q_a0", q_a0, 0);
    chk("sweep_q_b0", q_b0, 0);
    chk("sweep_q_b1", q_b1, 0);

    for (int i = 0; i < 16; i += 3) begin
      rd(0, 4'(i), CV, CV);
      rd(1, 4'(i + 1), CV, CV);
      tick();
    end
    idle();
    tick(); tick(); tick(); tick();

    for (int i = 0; i < 4; i++) chk("sb_empty", 32'(sb[i].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
